keypad_scanner: RTL and testbench

//  Drives the 4x3 phone-style key matrix and produces debounced key levels and press events.

---
 rtl/keypad_pkg.sv | 53 +++++
 rtl/keypad_debounce.sv | 76 +++++++
 rtl/keypad_scanner.sv | 102 ++++++++++
 tb/tb_keypad_scanner.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keypad_pkg: key indices, key codes and the index-to-code mapping shared by  |
// | the 4x3 keypad scanner and its debounce stage.       Revision: 1.0         |
// +----------------------------------------------------------------------------+
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  // Key index = row*3 + col
  localparam int KEY_IDX_1    = 0;
  localparam int KEY_IDX_2    = 1;
  localparam int KEY_IDX_3    = 2;
  localparam int KEY_IDX_4    = 3;
  localparam int KEY_IDX_5    = 4;
  localparam int KEY_IDX_6    = 5;
  localparam int KEY_IDX_7    = 6;
  localparam int KEY_IDX_8    = 7;
  localparam int KEY_IDX_9    = 8;
  localparam int KEY_IDX_STAR = 9;
  localparam int KEY_IDX_0    = 10;
  localparam int KEY_IDX_HASH = 11;

  localparam logic [3:0] KEY_CODE_STAR = 4'hA;
  localparam logic [3:0] KEY_CODE_HASH = 4'hB;

  function automatic logic [3:0] idx_to_code(input logic [3:0] index);
    logic [3:0] code;
    code = 4'h0;
    case (index)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
      4'd5, 4'd6, 4'd7, 4'd8:  code = index + 4'd1;
      4'd9:                    code = KEY_CODE_STAR;
      4'd10:                   code = 4'h0;
      4'd11:                   code = KEY_CODE_HASH;
      default:                 code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] lowest_set_idx(input logic [NUM_KEYS-1:0] keys);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keypad_debounce: commits a full-matrix snapshot once it has been stable for |
// | DEBOUNCE_FRAMES frames and pulses key_press on new presses. Revision: 1.0   |
// +----------------------------------------------------------------------------+
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_valid,
  input  logic [NUM_KEYS-1:0] snapshot,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                key_press,
  output logic [3:0]          key_code
);

  localparam logic [3:0] MATCH_MAX = 4'(DEBOUNCE_FRAMES);

  logic [NUM_KEYS-1:0] last_snap_q, last_snap_d;
  logic [3:0]          match_cnt_q, match_cnt_d;
  logic [NUM_KEYS-1:0] key_state_q, key_state_d;
  logic                key_press_q, key_press_d;
  logic [3:0]          key_code_q,  key_code_d;
  logic [NUM_KEYS-1:0] new_keys;

  always_comb begin
    last_snap_d = last_snap_q;
    match_cnt_d = match_cnt_q;
    key_state_d = key_state_q;
    key_press_d = 1'b0;
    key_code_d  = key_code_q;
    new_keys    = '0;
    if (frame_valid) begin
      if (snapshot != last_snap_q) begin
        last_snap_d = snapshot;
        match_cnt_d = 4'd1;
      end else if (match_cnt_q < MATCH_MAX) begin
        match_cnt_d = match_cnt_q + 4'd1;
      end
      // Commit only on an actual change so a saturated, stable matrix stays quiet.
      if ((match_cnt_d == MATCH_MAX) && (last_snap_d != key_state_q)) begin
        key_state_d = last_snap_d;
        new_keys    = last_snap_d & ~key_state_q;
        if (new_keys != '0) begin
          key_press_d = 1'b1;
          key_code_d  = idx_to_code(lowest_set_idx(new_keys));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_snap_q <= '0;
      match_cnt_q <= 4'd0;
      key_state_q <= '0;
      key_press_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      last_snap_q <= last_snap_d;
      match_cnt_q <= match_cnt_d;
      key_state_q <= key_state_d;
      key_press_q <= key_press_d;
      key_code_q  <= key_code_d;
    end
  end

  assign key_state = key_state_q;
  assign key_press = key_press_q;
  assign key_code  = key_code_q;

endmodule : keypad_debounce
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keypad_scanner: scans a 4x3 active-low key matrix column by column and      |
// | hands full-matrix snapshots to the debounce stage.       Revision: 1.0      |
// +----------------------------------------------------------------------------+
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] keypad_row,
  output logic [NUM_COLS-1:0] keypad_col,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                key_press,
  output logic [3:0]          key_code,
  output logic                key0,
  output logic                key8,
  output logic                key_star
);

  localparam int                DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [1:0]        COL_LAST = 2'(NUM_COLS - 1);

  logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
  logic [NUM_ROWS-1:0] pressed;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [1:0]          col_sel_q, col_sel_d;
  logic [NUM_COLS-1:0] keypad_col_q, keypad_col_d;
  logic [NUM_KEYS-1:0] snapshot_q, snapshot_d;
  logic                frame_valid_q, frame_valid_d;
  logic                slot_end;

  // Rows idle high through pull-ups, so the synchronizer resets to "nothing pressed".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= keypad_row;
      row_sync_q <= row_meta_q;
    end
  end

  assign pressed  = ~row_sync_q;
  assign slot_end = (div_q == DIV_LAST);

  always_comb begin
    div_d         = slot_end ? '0 : div_q + 1'b1;
    col_sel_d     = col_sel_q;
    snapshot_d    = snapshot_q;
    frame_valid_d = slot_end && (col_sel_q == COL_LAST);
    if (slot_end) begin
      col_sel_d = (col_sel_q == COL_LAST) ? 2'd0 : col_sel_q + 2'd1;
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          if (col_sel_q == 2'(c)) snapshot_d[r*NUM_COLS + c] = pressed[r];
        end
      end
    end
    // Drive follows the next column so it switches on the same edge as col_sel.
    keypad_col_d = ~(NUM_COLS'(1) << col_sel_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q         <= '0;
      col_sel_q     <= 2'd0;
      keypad_col_q  <= 3'b110;
      snapshot_q    <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      col_sel_q     <= col_sel_d;
      keypad_col_q  <= keypad_col_d;
      snapshot_q    <= snapshot_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk         (clk),
    .rst_n       (rst),
    .frame_valid (frame_valid_q),
    .snapshot    (snapshot_q),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_code    (key_code)
  );

  assign keypad_col = keypad_col_q;
  assign key0       = key_state[KEY_IDX_0];
  assign key8       = key_state[KEY_IDX_8];
  assign key_star   = key_state[KEY_IDX_STAR];

endmodule : keypad_scanner
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_keypad_scanner: directed test of keypad_scanner with a behavioural key   |
// | matrix (SCAN_DIV=4, DEBOUNCE_FRAMES=3).                  Revision: 1.0      |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  keypad_row;
  logic [2:0]  keypad_col;
  logic [11:0] key_state;
  logic        key_press;
  logic [3:0]  key_code;
  logic        key0, key8, key_star;

  logic [11:0] held = 12'h000;
  int          press_cnt = 0;
  logic [3:0]  last_code = 4'h0;
  int          errors = 0;
  int          checks = 0;

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .keypad_row (keypad_row),
    .keypad_col (keypad_col),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_code   (key_code),
    .key0       (key0),
    .key8       (key8),
    .key_star   (key_star)
  );

  always #5 clk = ~clk;

  // A held key pulls its row low only while its column is driven low.
  always_comb begin
    keypad_row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (held[r*3 + c] && !keypad_col[c]) keypad_row[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (key_press) begin
      press_cnt = press_cnt + 1;
      last_code = key_code;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int  p;
    int  n;
    logic saw0;

    // 1. Reset state and column walk
    rst  = 1'b0;
    held = 12'h000;
    repeat (3) tick();
    check("reset_col",   32'(keypad_col), 32'h6);
    check("reset_state", 32'(key_state),  32'h0);
    check("reset_press", 32'(key_press),  32'h0);
    rst = 1'b1;
    repeat (3) tick();
    check("col_slot0", 32'(keypad_col), 32'h6);
    tick();
    check("col_slot1", 32'(keypad_col), 32'h5);
    repeat (4) tick();
    check("col_slot2", 32'(keypad_col), 32'h3);
    repeat (4) tick();
    check("col_wrap",  32'(keypad_col), 32'h6);

    // 2. Hold '8'
    p    = press_cnt;
    held = 12'h080;
    n    = 0;
    while (!key8 && n < 51) begin tick(); n++; end
    check("key8_rise",    32'(key8),          32'h1);
    check("key8_state",   32'(key_state),     32'h080);
    tick();
    check("key8_pulses",  32'(press_cnt - p), 32'h1);
    check("key8_code",    32'(last_code),     32'h8);
    repeat (40) tick();
    check("key8_no_more", 32'(press_cnt - p), 32'h1);

    held = 12'h000;
    n    = 0;
    while (key_state != 12'h000 && n < 51) begin tick(); n++; end
    check("key8_release", 32'(key_state), 32'h0);

    // 3. Hold '*', then release
    p    = press_cnt;
    held = 12'h200;
    n    = 0;
    while (!key_star && n < 51) begin tick(); n++; end
    check("star_rise",   32'(key_star),      32'h1);
    tick();
    check("star_pulses", 32'(press_cnt - p), 32'h1);
    check("star_code",   32'(last_code),     32'hA);
    held = 12'h000;
    n    = 0;
    while (key_star && n < 51) begin tick(); n++; end
    check("star_fall",     32'(key_star),      32'h0);
    repeat (2) tick();
    check("star_rel_nopulse", 32'(press_cnt - p), 32'h1);

    // 4. Bounce '0' every 10 cycles for 100 cycles
    p    = press_cnt;
    saw0 = 1'b0;
    for (int t = 0; t < 10; t++) begin
      held = (t % 2 == 0) ? 12'h400 : 12'h000;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (key0) saw0 = 1'b1;
      end
    end
    held = 12'h000;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (key0) saw0 = 1'b1;
    end
    check("bounce_key0",  32'(saw0),          32'h0);
    check("bounce_press", 32'(press_cnt - p), 32'h0);

    // 5. '1' and '#' together
    p    = press_cnt;
    held = 12'h801;
    n    = 0;
    while (key_state != 12'h801 && n < 63) begin tick(); n++; end
    check("dual_state", 32'(key_state), 32'h801);
    tick();
    check("dual_pulses", 32'(press_cnt - p), 32'h1);
    check("dual_code",   32'(last_code),     32'h1);
    repeat (30) tick();
    check("dual_no_more", 32'(press_cnt - p), 32'h1);

    // 6. Commit '5', reset mid-press, recover
    p    = press_cnt;
    held = 12'h010;
    n    = 0;
    while (key_state != 12'h010 && n < 63) begin tick(); n++; end
    check("five_state", 32'(key_state), 32'h010);
    tick();
    check("five_pulses", 32'(press_cnt - p), 32'h1);
    check("five_code",   32'(last_code),     32'h5);
    repeat (5) tick();
    rst = 1'b0;
    #1;
    check("midrst_state", 32'(key_state),  32'h0);
    check("midrst_press", 32'(key_press),  32'h0);
    check("midrst_col",   32'(keypad_col), 32'h6);
    check("midrst_code",  32'(key_code),   32'h0);
    repeat (2) tick();
    rst = 1'b1;
    p   = press_cnt;
    n   = 0;
    while (press_cnt == p && n < 60) begin tick(); n++; end
    check("repress_pulses", 32'(press_cnt - p), 32'h1);
    check("repress_code",   32'(last_code),     32'h5);
    check("repress_state",  32'(key_state),     32'h010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_keypad_scanner
`default_nettype wire
